// File: rtl/seg_scan_display.sv
// Multiplexed common-anode 7-segment driver: hex or decimal (sequential double-dabble)
// display of a 4*DIGITS-bit value with decimal points, leading-zero blanking and scan.
module seg_scan_display #(
  parameter int DIGITS   = 8,
  parameter int SCAN_DIV = 100000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   data,
  input  logic                  radix,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  blank_zeros,
  input  logic                  enable,
  output logic [7:0]            cathode,
  output logic [DIGITS-1:0]     anode,
  output logic                  busy,
  output logic                  updated
);

  localparam int W     = 4 * DIGITS;
  localparam int CNT_W = $clog2(W + 1);
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_CONV = 1'b1;

  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(W);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

  logic [0:0]        state;
  logic [W-1:0]      shadow;
  logic [W-1:0]      shift_reg;
  logic [W-1:0]      bcd;
  logic [W-1:0]      bcd_adj;
  logic [CNT_W-1:0]  bit_cnt;

  logic [DIV_W-1:0]  div_cnt;
  logic [IDX_W-1:0]  idx;
  logic              tick;

  logic [DIGITS-1:0] zero_from;
  logic              zero_run;
  logic [3:0]        cur_digit;
  logic              cur_dp;
  logic              cur_blank;
  logic [DIGITS-1:0] cur_onehot;

  function automatic logic [7:0] seg(input logic [3:0] v);
    case (v)
      4'h0:    seg = 8'h03;
      4'h1:    seg = 8'h9F;
      4'h2:    seg = 8'h25;
      4'h3:    seg = 8'h0D;
      4'h4:    seg = 8'h99;
      4'h5:    seg = 8'h49;
      4'h6:    seg = 8'h41;
      4'h7:    seg = 8'h1F;
      4'h8:    seg = 8'h01;
      4'h9:    seg = 8'h09;
      4'hA:    seg = 8'h11;
      4'hB:    seg = 8'hC1;
      4'hC:    seg = 8'h63;
      4'hD:    seg = 8'h85;
      4'hE:    seg = 8'h61;
      default: seg = 8'h71;
    endcase
  endfunction

  // Double-dabble correction: every BCD nibble of 5 or more gets +3 before the shift
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      shadow    <= '0;
      shift_reg <= '0;
      bcd       <= '0;
      bit_cnt   <= '0;
      updated   <= 1'b0;
    end else begin
      updated <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (radix) begin
            shift_reg <= data;
            bcd       <= '0;
            bit_cnt   <= '0;
            state     <= ST_CONV;
          end else begin
            shadow  <= data;
            updated <= 1'b1;
          end
        end
        ST_CONV: begin
          // Bit shifted out of the top nibble is dropped, giving data mod 10^DIGITS
          if (bit_cnt == LAST_SHIFT) begin
            shadow  <= bcd;
            updated <= 1'b1;
            state   <= ST_IDLE;
          end else begin
            bcd       <= {bcd_adj[W-2:0], shift_reg[W-1]};
            shift_reg <= shift_reg << 1;
            bit_cnt   <= bit_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state == ST_CONV);

  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      div_cnt <= '0;
      idx     <= '0;
    end else if (tick) begin
      div_cnt <= '0;
      idx     <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // zero_from[i] is set when shadow digits i..DIGITS-1 are all zero
  always_comb begin
    zero_from = '0;
    zero_run  = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run     = zero_run && (shadow[4*i +: 4] == 4'd0);
      zero_from[i] = zero_run;
    end
  end

  always_comb begin
    cur_digit  = 4'd0;
    cur_dp     = 1'b0;
    cur_blank  = 1'b0;
    cur_onehot = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_digit     = shadow[4*i +: 4];
        cur_dp        = dp[i];
        cur_blank     = blank_zeros && (i != 0) && zero_from[i];
        cur_onehot[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      anode   <= '1;
      cathode <= 8'hFF;
    end else if (!enable || cur_blank) begin
      anode   <= '1;
      cathode <= 8'hFF;
    end else begin
      anode   <= ~cur_onehot;
      cathode <= seg(cur_digit) & ~{7'b0, cur_dp};
    end
  end

endmodule
